// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: Funct3 sizes, FSM states,
// wait-counter width and byte-enable patterns.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [1:0] mem_state_t;
  localparam mem_state_t S_IDLE = 2'd0;
  localparam mem_state_t S_BUSY = 2'd1;
  localparam mem_state_t S_DONE = 2'd2;

  localparam int WAIT_W = 8;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage

// File: rtl/lsu_data_align.sv
// Combinational data path of the load/store unit: store lane steering, load
// extraction with sign/zero extension, and access fault detection.
module lsu_data_align
  import mem_pkg::*;
(
  input  logic        access,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        fault
);

  logic        illegal;
  logic        misaligned;
  logic [31:0] shifted;
  logic [7:0]  load_byte;
  logic [15:0] load_half;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      F3_B:  misaligned = 1'b0;
      F3_H:  misaligned = offset[0];
      F3_W:  misaligned = |offset;
      F3_BU: illegal = is_store;
      F3_HU: begin
        illegal    = is_store;
        misaligned = offset[0];
      end
      default: illegal = 1'b1;
    endcase
    fault = access & (illegal | misaligned);
  end

  // Reads always fetch the whole word; the byte/half is picked out on return.
  always_comb begin
    be    = BE_WORD;
    wdata = 32'h0;
    if (is_store) begin
      case (funct3[1:0])
        2'b00: begin
          be    = BE_BYTE << offset;
          wdata = {4{store_data[7:0]}};
        end
        2'b01: begin
          be    = offset[1] ? BE_HALF_HI : BE_HALF_LO;
          wdata = {2{store_data[15:0]}};
        end
        default: begin
          be    = BE_WORD;
          wdata = store_data;
        end
      endcase
    end
  end

  always_comb begin
    shifted   = load_word >> {load_offset, 3'b000};
    load_byte = shifted[7:0];
    load_half = load_offset[1] ? load_word[31:16] : load_word[15:0];
    case (load_funct3)
      F3_B:    load_data = {{24{load_byte[7]}}, load_byte};
      F3_H:    load_data = {{16{load_half[15]}}, load_half};
      F3_BU:   load_data = {24'h0, load_byte};
      F3_HU:   load_data = {16'h0, load_half};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM-stage load/store unit: issues one req/ack transaction per memory instruction,
// stalls the pipeline until it completes or times out, and formats load data.
module memory_access_stage
  import mem_pkg::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MisalignedM,
  output logic        BusErrM,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata
);

  mem_state_t        state;
  logic [WAIT_W-1:0] wait_count;
  logic [2:0]        load_funct3;
  logic [1:0]        load_offset;
  logic              access;
  logic              fault;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [31:0]       load_data;

  assign access = MemReadM | MemWriteM;

  lsu_data_align u_align (
    .access      (access),
    .is_store    (MemWriteM),
    .funct3      (Funct3M),
    .offset      (ALUResultM[1:0]),
    .store_data  (WriteDataM),
    .load_funct3 (load_funct3),
    .load_offset (load_offset),
    .load_word   (dmem_rdata),
    .be          (be),
    .wdata       (wdata),
    .load_data   (load_data),
    .fault       (fault)
  );

  assign MisalignedM = fault;
  assign StallM      = (state == S_BUSY) || ((state == S_IDLE) && access && !fault);

  // Size and offset are latched with the request so formatting does not depend on
  // the pipeline holding its inputs steady through BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      wait_count  <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= 32'h0;
      dmem_be     <= 4'h0;
      dmem_wdata  <= 32'h0;
      load_funct3 <= 3'b000;
      load_offset <= 2'b00;
      ReadDataM   <= 32'h0;
      BusErrM     <= 1'b0;
    end else begin
      BusErrM <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access && !fault) begin
            dmem_req    <= 1'b1;
            dmem_we     <= MemWriteM;
            dmem_addr   <= {ALUResultM[31:2], 2'b00};
            dmem_be     <= be;
            dmem_wdata  <= wdata;
            load_funct3 <= Funct3M;
            load_offset <= ALUResultM[1:0];
            wait_count  <= '0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) ReadDataM <= load_data;
            state <= S_DONE;
          end else if (wait_count == WAIT_W'(MAX_WAIT - 1)) begin
            dmem_req  <= 1'b0;
            ReadDataM <= 32'h0;
            BusErrM   <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_count <= wait_count + 1'b1;
          end
        end
        S_DONE: begin
          wait_count <= '0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Scoreboard bench: stimulus queues expected transactions, a monitor checks each
// completed access against the queue, and a responder models the data memory.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b000;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignedM;
  logic        BusErrM;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;

  always #5 clk = ~clk;

  memory_access_stage #(.MAX_WAIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallM(StallM), .MisalignedM(MisalignedM),
    .BusErrM(BusErrM), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        buserr;
    int          req_cycles;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          done_count = 0;
  int          ack_delay = 255;
  logic [31:0] ack_data = 32'h0;
  logic        late_ack = 1'b0;
  logic [31:0] last_rd = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk(logic we, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata,
                              logic [31:0] rdata, logic buserr, int req_cycles);
    exp_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    e.rdata = rdata; e.buserr = buserr; e.req_cycles = req_cycles;
    return e;
  endfunction

  // Memory responder: acks after ack_delay BUSY cycles (255 = never).
  initial begin
    int cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_req && rst_n) begin
        dmem_ack   = (cnt == ack_delay);
        dmem_rdata = (cnt == ack_delay) ? ack_data : 32'h0;
        cnt++;
      end else begin
        dmem_ack   = late_ack;
        dmem_rdata = late_ack ? 32'hFFFF_FFFF : 32'h0;
        cnt = 0;
      end
    end
  end

  // Monitor: a falling StallM marks the DONE cycle of a transaction.
  initial begin
    logic        prev_req = 1'b0;
    logic        prev_stall = 1'b0;
    int          reqc = 0;
    logic        cwe = 1'b0;
    logic [31:0] caddr = 32'h0;
    logic [31:0] cwd = 32'h0;
    logic [3:0]  cbe = 4'h0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_req = 1'b0; prev_stall = 1'b0; reqc = 0;
      end else begin
        if (dmem_req && !prev_req) begin
          cwe = dmem_we; caddr = dmem_addr; cbe = dmem_be; cwd = dmem_wdata; reqc = 0;
        end
        if (dmem_req) reqc++;
        if (prev_stall && !StallM) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_completion actual=1 required=0");
          end else begin
            e = sb.pop_front();
            check("dmem_we", {31'h0, cwe}, {31'h0, e.we});
            check("dmem_addr", caddr, e.addr);
            check("dmem_be", {28'h0, cbe}, {28'h0, e.be});
            if (e.we) check("dmem_wdata", cwd, e.wdata);
            check("ReadDataM", ReadDataM, e.rdata);
            check("BusErrM", {31'h0, BusErrM}, {31'h0, e.buserr});
            check("req_cycles", reqc, e.req_cycles);
            $display("txn we=%0d addr=0x%08h be=%04b rd=0x%08h buserr=%0d req_cycles=%0d",
                     cwe, caddr, cbe, ReadDataM, BusErrM, reqc);
          end
          done_count++;
        end
        prev_req = dmem_req;
        prev_stall = StallM;
      end
    end
  end

  task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input int delay, input logic [31:0] rdata, input exp_t e);
    int start = done_count;
    ack_delay = delay;
    ack_data  = rdata;
    sb.push_back(e);
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = addr; WriteDataM = wd;
    #1;
    check("StallM_issue", {31'h0, StallM}, 32'h1);
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done_count != start) break;
    end
    if (done_count == start) begin
      checks++; failures++;
      $display("FAIL completion_timeout actual=0 required=1");
      void'(sb.pop_back());
    end
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=hang required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    check("rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
    check("rst_dmem_addr", dmem_addr, 32'h0);
    check("rst_dmem_be", {28'h0, dmem_be}, 32'h0);
    check("rst_ReadDataM", ReadDataM, 32'h0);
    check("rst_BusErrM", {31'h0, BusErrM}, 32'h0);
    check("rst_StallM", {31'h0, StallM}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF,
        mk(0, 32'h100, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1));
    run(1, 0, 3'b000, 32'h203, 32'h0, 1, 32'h8012_3456,
        mk(0, 32'h200, 4'hF, 32'h0, 32'hFFFF_FF80, 0, 2));
    run(1, 0, 3'b100, 32'h203, 32'h0, 0, 32'h8012_3456,
        mk(0, 32'h200, 4'hF, 32'h0, 32'h0000_0080, 0, 1));
    run(1, 0, 3'b101, 32'h202, 32'h0, 0, 32'hBEEF_1234,
        mk(0, 32'h200, 4'hF, 32'h0, 32'h0000_BEEF, 0, 1));
    run(1, 0, 3'b001, 32'h202, 32'h0, 1, 32'hBEEF_1234,
        mk(0, 32'h200, 4'hF, 32'h0, 32'hFFFF_BEEF, 0, 2));
    last_rd = 32'hFFFF_BEEF;
    run(0, 1, 3'b000, 32'h301, 32'h0000_00AB, 0, 32'h0,
        mk(1, 32'h300, 4'b0010, 32'hABAB_ABAB, last_rd, 0, 1));
    run(0, 1, 3'b001, 32'h302, 32'h1234_CDEF, 2, 32'h0,
        mk(1, 32'h300, 4'b1100, 32'hCDEF_CDEF, last_rd, 0, 3));
    run(1, 1, 3'b010, 32'h404, 32'hCAFE_F00D, 0, 32'h0,
        mk(1, 32'h404, 4'b1111, 32'hCAFE_F00D, last_rd, 0, 1));

    // Misaligned word load: fault flagged, no request, no stall.
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h102;
    #1;
    check("mis_MisalignedM", {31'h0, MisalignedM}, 32'h1);
    check("mis_StallM", {31'h0, StallM}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    check("mis_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("mis_ReadDataM", ReadDataM, last_rd);
    MemReadM = 1'b0;
    // Unsigned size on a store is illegal.
    MemWriteM = 1'b1; Funct3M = 3'b100; ALUResultM = 32'h300;
    #1;
    check("ill_MisalignedM", {31'h0, MisalignedM}, 32'h1);
    check("ill_StallM", {31'h0, StallM}, 32'h0);
    @(posedge clk); #1;
    check("ill_dmem_req", {31'h0, dmem_req}, 32'h0);
    MemWriteM = 1'b0;
    #1;
    check("idle_MisalignedM", {31'h0, MisalignedM}, 32'h0);

    run(1, 0, 3'b010, 32'h500, 32'h0, 255, 32'h0,
        mk(0, 32'h500, 4'hF, 32'h0, 32'h0, 1, 4));
    check("buserr_pulse_end", {31'h0, BusErrM}, 32'h0);
    run(1, 0, 3'b010, 32'h104, 32'h0, 1, 32'h1357_2468,
        mk(0, 32'h104, 4'hF, 32'h0, 32'h1357_2468, 0, 2));

    // Reset asserted between edges while BUSY; a late ack afterwards is ignored.
    ack_delay = 255;
    @(posedge clk); #1;
    MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h600;
    @(posedge clk); #2;
    check("pre_rst_dmem_req", {31'h0, dmem_req}, 32'h1);
    rst_n = 1'b0; MemReadM = 1'b0;
    #1;
    check("async_rst_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("async_rst_StallM", {31'h0, StallM}, 32'h0);
    check("async_rst_ReadDataM", ReadDataM, 32'h0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    late_ack = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    late_ack = 1'b0;
    check("late_ack_dmem_req", {31'h0, dmem_req}, 32'h0);
    check("late_ack_StallM", {31'h0, StallM}, 32'h0);
    check("late_ack_ReadDataM", ReadDataM, 32'h0);

    repeat (2) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
